// File: rtl/sp1_fifo.sv
// Single-clock first-word-fall-through FIFO with sticky overflow/underflow flags.
// Dropped requests leave storage, pointers and count untouched.
module sp1_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_d,
  input  logic          rd_en,
  output logic [DW-1:0] rd_q,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf
);

  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push_s;
  logic          pop_s;

  // Next-state: accept a request only when the FIFO can honour it.
  always_comb begin
    push_s  = wr_en & ~full_q;
    pop_s   = rd_en & ~empty_q;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wr_en & full_q);
    udf_d   = udf_q | (rd_en & empty_q);

    if (push_s) begin
      mem_d[wptr_q] = wr_d;
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are registered so they never depend combinationally on wr_en/rd_en.
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is not reset; stale words are hidden while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= mem_d;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Head-of-queue output, forced to zero while empty.
  always_comb begin
    if (empty_q) begin
      rd_q = '0;
    end else begin
      rd_q = mem_q[rptr_q];
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: doc/sp1_fifo.md
SP1_FIFO -- requirements
Module: sp1_fifo

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter AW, default 2: pointer width, equal to log2(DEPTH).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port wr_en  input  1: push request, driven from upstream sp1_ff q-side logic.
REQ-007 SHALL have port wr_d  input  DW: push data.
REQ-008 SHALL have port rd_en  input  1: pop request.
REQ-009 SHALL have port rd_q  output  DW: head-of-queue data, first-word-fall-through.
REQ-010 SHALL have port full  output  1: count == DEPTH.
REQ-011 SHALL have port empty  output  1: count == 0.
REQ-012 SHALL have port count  output  AW+1: number of valid entries.
REQ-013 SHALL have port ovf  output  1: sticky flag, set by a push that was dropped.
REQ-014 SHALL have port udf  output  1: sticky flag, set by a pop that was dropped.

Function
REQ-015 SHALL hold state in DEPTH x DW storage, an AW-bit write pointer, an AW-bit read pointer and an (AW+1)-bit count.
REQ-016 SHALL accept a push when wr_en=1 and full=0: store wr_d at wptr, then wptr+1 modulo DEPTH.
REQ-017 SHALL accept a pop when rd_en=1 and empty=0: rptr+1 modulo DEPTH.
REQ-018 SHALL drive rd_q combinationally as mem[rptr] when empty=0, and as all-zeros when empty=1.
REQ-019 SHALL present pushed data on rd_q in the cycle after the accepting edge when the FIFO was empty; push-to-rd_q latency is 1 cycle.
REQ-020 SHALL drive full, empty and count directly from registered state, with no combinational path from wr_en or rd_en.
REQ-021 SHALL update count by +1 on a push only, -1 on a pop only, and 0 on both or neither.
REQ-022 SHALL, when full=1 with wr_en=1 and rd_en=1, accept the pop and drop the push; count becomes DEPTH-1 and ovf is set.
REQ-023 SHALL, when empty=1 with wr_en=1 and rd_en=1, accept the push and drop the pop; count becomes 1 and udf is set.
REQ-024 SHALL, when 0<count<DEPTH with wr_en=1 and rd_en=1, accept both; count is unchanged.
REQ-025 SHALL set ovf on any cycle with wr_en=1 and full=1; ovf holds 1 until reset.
REQ-026 SHALL set udf on any cycle with rd_en=1 and empty=1; udf holds 1 until reset.
REQ-027 SHALL leave storage, pointers and count unchanged on a dropped request.
REQ-028 SHALL wrap pointers from DEPTH-1 to 0 with no bubble and no data loss.

Reset
REQ-029 SHALL, on a rising clk edge with rst=0, clear wptr, rptr, count, ovf and udf to 0, and ignore wr_en and rd_en on that edge.
REQ-030 SHALL give empty=1, full=0, count=0 and rd_q=0 in the cycle after reset.
REQ-031 SHALL NOT reset storage contents; they are unobservable while empty=1.
REQ-032 SHALL, on reset asserted mid-operation with count>0, discard all entries; the first push after reset is the head.

Verification
REQ-033 Reset sequence: hold rst=0 for 5 edges, then release -> empty=1, full=0, count=0, rd_q=00000000, ovf=udf=0.
REQ-034 Push and pop order: push ffffffff, 00000000, 12345678, cafecafe; then pop 4 -> rd_q sequence ffffffff, 00000000, 12345678, cafecafe; empty=1 afterwards; count steps 1,2,3,4,3,2,1,0.
REQ-035 Overflow: with 4 entries, push beefbeef -> full stays 1, ovf=1, count=4, head unchanged; pops return the original 4 values only.
REQ-036 Underflow and simultaneous push+pop on empty: pop on empty -> udf=1, count=0; wr_en=rd_en=1 with wr_d=bbbbbbbb on empty -> count=1, rd_q=bbbbbbbb next cycle.
REQ-037 Wrap and streaming: 10 back-to-back cycles of push and pop (data 1..10) after one prefill -> rd_q output in order, count constant, no ovf/udf.
REQ-038 Reset mid-operation: 3 entries held, assert rst=0 for 1 edge -> count=0, empty=1; push 5a5a5a5a -> rd_q=5a5a5a5a.
